// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//   Shared types and constants for the phase sequencer: controller states,
//   the opcodes the sequencer itself reacts to, the four phase numbers, and a
//   helper that tells whether an opcode produces a register writeback.
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] PH_FETCH = 2'd0;
  localparam logic [1:0] PH_WB    = 2'd1;
  localparam logic [1:0] PH_DEC   = 2'd2;
  localparam logic [1:0] PH_RD    = 2'd3;

  // Branches and halt leave the register file untouched; everything else
  // writes its rA during the writeback phase of the following instruction.
  function automatic logic writes_back(input logic [2:0] op);
    return !((op == OP_BR) || (op == OP_HALT));
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// phase_sequencer_if
//   Bundles everything the sequencer exchanges with its neighbours:
//     start / instr / branch_taken / branch_target  -> into the sequencer
//     pc                                            -> instruction ROM address
//     counter / raddrA / raddrB / waddr / write_en  -> register file
//     opcode_q                                      -> ALU
//     done                                          -> high while halted
//   master : the sequencer side
//   slave  : the environment (ROM, register file, ALU, host)
// -----------------------------------------------------------------------------
interface phase_sequencer_if #(
  parameter int PCW = 8,
  parameter int AW  = 3,
  parameter int IW  = 9
);

  logic           start;
  logic [IW-1:0]  instr;
  logic           branch_taken;
  logic [PCW-1:0] branch_target;

  logic [PCW-1:0] pc;
  logic [1:0]     counter;
  logic [AW-1:0]  raddrA;
  logic [AW-1:0]  raddrB;
  logic [AW-1:0]  waddr;
  logic           write_en;
  logic [2:0]     opcode_q;
  logic           done;

  modport master (
    input  start, instr, branch_taken, branch_target,
    output pc, counter, raddrA, raddrB, waddr, write_en, opcode_q, done
  );

  modport slave (
    output start, instr, branch_taken, branch_target,
    input  pc, counter, raddrA, raddrB, waddr, write_en, opcode_q, done
  );

endinterface

// File: rtl/phase_ctr.sv
// -----------------------------------------------------------------------------
// phase_ctr
//   Two-bit phase counter. Counts 0..3 and wraps while en is high; clr forces
//   it to 0 on the next edge and takes priority over en.
//   CLK    in  clock
//   init_n in  asynchronous active-low reset
//   en     in  advance one phase
//   clr    in  synchronous clear to phase 0
//   count  out current phase
// -----------------------------------------------------------------------------
module phase_ctr (
  input  logic       CLK,
  input  logic       init_n,
  input  logic       en,
  input  logic       clr,
  output logic [1:0] count
);

  // NOTE: state is assigned with <= so every flop samples the pre-edge value
  // of every other flop; = here would create order-dependent simulation.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n)  count <= 2'd0;
    else if (clr) count <= 2'd0;
    else if (en)  count <= count + 2'd1;
  end

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//   Control stage in front of the 8x8 register file. Fetches instructions by
//   PC and steps each one through four phases:
//     0 fetch (latch instr)      1 writeback of the previous instruction
//     2 decode (read addresses)  3 operand read, PC advance / branch
//   A halt opcode retires into DRAIN, which runs one more fetch + writeback
//   slot and then parks in HALTED with done high until the next start.
//   CLK    in  clock, all state on posedge
//   init_n in  asynchronous active-low reset
//   bus    master side of phase_sequencer_if (see interface for signal list)
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module phase_sequencer
  import seq_pkg::*;
#(
  parameter int PCW = 8,
  parameter int AW  = 3,
  parameter int IW  = 9
) (
  input  logic                 CLK,
  input  logic                 init_n,
  phase_sequencer_if.master    bus
);

  localparam logic [PCW-1:0] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

  seq_state_t     state_q, state_d;
  logic [1:0]     phase;

  // One-cycle strobes from the controller to the datapath registers.
  logic           go;        // accepted start
  logic           ctr_en;
  logic           ctr_clr;
  logic           latch_en;  // end of phase 0 in RUN
  logic           wb_en;     // end of phase 0 in RUN or DRAIN
  logic           dec_en;    // end of phase 2
  logic           retire;    // end of phase 3

  logic [IW-1:0]  instr_q;
  logic [PCW-1:0] pc_q;
  logic [AW-1:0]  raddr_a_q, raddr_b_q, waddr_q;
  logic           write_en_q;
  logic           done_q;
  logic           prev_wr_q;
  logic [AW-1:0]  prev_ra_q;

  logic [2:0]     op;
  logic [AW-1:0]  instr_ra, instr_rb;

  assign op       = instr_q[IW-1 -: 3];
  assign instr_ra = instr_q[AW +: AW];
  assign instr_rb = instr_q[0 +: AW];

  phase_ctr u_phase_ctr (
    .CLK    (CLK),
    .init_n (init_n),
    .en     (ctr_en),
    .clr    (ctr_clr),
    .count  (phase)
  );

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d  = state_q;
    go       = 1'b0;
    ctr_en   = 1'b0;
    ctr_clr  = 1'b0;
    latch_en = 1'b0;
    wb_en    = 1'b0;
    dec_en   = 1'b0;
    retire   = 1'b0;

    unique case (state_q)
      IDLE, HALTED: begin
        if (bus.start) begin
          state_d = RUN;
          go      = 1'b1;
          ctr_clr = 1'b1;
        end
      end

      RUN: begin
        ctr_en = 1'b1;
        unique case (phase)
          PH_FETCH: begin
            latch_en = 1'b1;
            wb_en    = 1'b1;
          end
          PH_WB:  ;
          PH_DEC: dec_en = 1'b1;
          PH_RD: begin
            retire = 1'b1;
            if (op == OP_HALT) state_d = DRAIN;
          end
        endcase
      end

      // Only phases 0 and 1 are visited here; the counter is cleared at the
      // end of phase 1 so HALTED always presents phase 0.
      DRAIN: begin
        ctr_en = 1'b1;
        if (phase == PH_FETCH) begin
          wb_en = 1'b1;
        end else begin
          state_d = HALTED;
          ctr_clr = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      pc_q       <= '0;
      instr_q    <= '0;
      raddr_a_q  <= '0;
      raddr_b_q  <= '0;
      waddr_q    <= '0;
      write_en_q <= 1'b0;
      done_q     <= 1'b0;
      prev_wr_q  <= 1'b0;
      prev_ra_q  <= '0;
    end else begin
      // write_en is a one-phase pulse: it is only re-armed when entering
      // phase 1, so it drops again in phases 2, 3 and 0.
      write_en_q <= 1'b0;
      done_q     <= (state_d == HALTED);

      if (wb_en) begin
        write_en_q <= prev_wr_q;
        waddr_q    <= prev_ra_q;
      end

      if (latch_en) instr_q <= bus.instr;

      if (dec_en) begin
        raddr_a_q <= instr_ra;
        raddr_b_q <= instr_rb;
      end

      if (retire) begin
        prev_wr_q <= writes_back(op);
        prev_ra_q <= instr_ra;
        if ((op == OP_BR) && bus.branch_taken) pc_q <= bus.branch_target;
        else                                   pc_q <= pc_q + PC_ONE;
      end

      // A fresh run must not write back whatever retired before it.
      if (go) begin
        pc_q      <= '0;
        prev_wr_q <= 1'b0;
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.counter  = phase;
  assign bus.raddrA   = raddr_a_q;
  assign bus.raddrB   = raddr_b_q;
  assign bus.waddr    = waddr_q;
  assign bus.write_en = write_en_q;
  // The opcode field of the fetch latch is itself a flop, so it is exported
  // directly instead of keeping a second copy.
  assign bus.opcode_q = op;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//   Self-checking bench for phase_sequencer. A directed vector table walks a
//   small program through fetch/writeback/branch/halt/drain, hand-written
//   sequences cover restart, not-taken branch, async reset and PC wrap, and
//   random programs are compared cycle by cycle against an instruction-level
//   model that expands each executed instruction into its four phases.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;
  import seq_pkg::*;

  logic CLK    = 1'b0;
  logic init_n = 1'b0;

  always #5 CLK = ~CLK;

  phase_sequencer_if bus ();

  phase_sequencer dut (
    .CLK    (CLK),
    .init_n (init_n),
    .bus    (bus)
  );

  logic [8:0] rom [256];
  assign bus.instr = rom[bus.pc];

  typedef struct {
    logic       start;
    logic       bt;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic [1:0] ctr;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wa;
    logic       we;
    logic [2:0] opq;
    logic       done;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(int s, int b, int t, int pc, int c, int ra, int rb,
                              int wa, int we, int op, int d);
    vec_t v;
    v.start = 1'(s);  v.bt = 1'(b);   v.tgt = 8'(t);
    v.pc    = 8'(pc); v.ctr = 2'(c);  v.ra  = 3'(ra); v.rb = 3'(rb);
    v.wa    = 3'(wa); v.we  = 1'(we); v.opq = 3'(op); v.done = 1'(d);
    return v;
  endfunction

  function automatic logic [23:0] pack_exp(input vec_t v);
    return {v.pc, v.ctr, v.ra, v.rb, v.wa, v.we, v.opq, v.done};
  endfunction

  function automatic logic [23:0] pack_dut();
    return {bus.pc, bus.counter, bus.raddrA, bus.raddrB, bus.waddr,
            bus.write_en, bus.opcode_q, bus.done};
  endfunction

  // Drive one cycle of inputs, let the edge happen, compare at the next negedge.
  task automatic apply(input vec_t v, input string name);
    bus.start         = v.start;
    bus.branch_taken  = v.bt;
    bus.branch_target = v.tgt;
    @(negedge CLK);
    bus.start = 1'b0;
    check(name, {8'h00, pack_dut()}, {8'h00, pack_exp(v)});
  endtask

  task automatic cyc(input logic s, input logic b, input logic [7:0] t);
    bus.start         = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    bus.start         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    @(negedge CLK);
    init_n = 1'b0;
    repeat (2) @(negedge CLK);
    init_n = 1'b1;
    @(negedge CLK);
  endtask

  // ---------------------------------------------------------------------------
  // Instruction-level reference model. Each executed instruction expands into
  // four expected cycles; a halt appends its drain slot and a few halted cycles.
  // ---------------------------------------------------------------------------
  vec_t       q [$];
  logic [7:0] m_pc;
  logic [1:0] m_ctr;
  logic [2:0] m_ra, m_rb, m_wa, m_opq, m_prev_ra;
  logic       m_we, m_done, m_prev_wr;

  function automatic logic rnd_start();
    return ($urandom_range(0, 7) == 0);
  endfunction

  task automatic push(input logic s, input logic b, input logic [7:0] t);
    vec_t v;
    v.start = s;    v.bt = b;     v.tgt = t;
    v.pc    = m_pc; v.ctr = m_ctr; v.ra = m_ra; v.rb = m_rb; v.wa = m_wa;
    v.we    = m_we; v.opq = m_opq; v.done = m_done;
    q.push_back(v);
  endtask

  task automatic build_round();
    int         n;
    bit         halted;
    logic [8:0] w;
    logic [2:0] op;
    logic       bt;
    logic [7:0] tgt;

    q.delete();
    m_pc = 8'h00; m_ctr = 2'd0; m_ra = 3'd0; m_rb = 3'd0; m_wa = 3'd0;
    m_opq = 3'd0; m_prev_ra = 3'd0; m_we = 1'b0; m_done = 1'b0; m_prev_wr = 1'b0;

    push(1'b0, 1'($urandom), 8'($urandom));
    push(1'b1, 1'($urandom), 8'($urandom));

    n = 0;
    halted = 1'b0;
    while (!halted && n < 40) begin
      w  = rom[m_pc];
      op = w[8:6];

      m_opq = op; m_wa = m_prev_ra; m_we = m_prev_wr; m_ctr = 2'd1;
      push(rnd_start(), 1'($urandom), 8'($urandom));

      m_we = 1'b0; m_ctr = 2'd2;
      push(rnd_start(), 1'($urandom), 8'($urandom));

      m_ra = w[5:3]; m_rb = w[2:0]; m_ctr = 2'd3;
      push(rnd_start(), 1'($urandom), 8'($urandom));

      bt  = 1'($urandom);
      tgt = 8'($urandom);
      m_prev_wr = !(op == OP_BR || op == OP_HALT);
      m_prev_ra = w[5:3];
      m_pc      = (op == OP_BR && bt) ? tgt : m_pc + 8'd1;
      m_ctr     = 2'd0;
      push(rnd_start(), bt, tgt);
      n++;

      if (op == OP_HALT) begin
        m_wa = m_prev_ra; m_we = m_prev_wr; m_ctr = 2'd1;
        push(rnd_start(), 1'($urandom), 8'($urandom));
        m_we = 1'b0; m_ctr = 2'd0; m_done = 1'b1;
        push(rnd_start(), 1'($urandom), 8'($urandom));
        repeat (3) push(1'b0, 1'($urandom), 8'($urandom));
        halted = 1'b1;
      end
    end
  endtask

  task automatic fill_random_rom();
    int r;
    int op;
    for (int i = 0; i < 256; i++) begin
      r  = int'($urandom_range(0, 31));
      op = (r == 0) ? 7 : ((r < 6) ? 6 : (r % 6));
      rom[i] = {3'(op), 6'($urandom)};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the end of the test");
    $fatal(1, "watchdog");
  end

  vec_t tbl [25];

  initial begin
    bus.start         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;

    // ---------------- directed table ----------------
    rom[8'h00] = 9'b000_001_010;
    rom[8'h01] = 9'b000_100_000;
    rom[8'h02] = 9'b110_101_011;
    rom[8'h20] = 9'b000_010_001;
    rom[8'h21] = 9'b111_000_000;
    rom[8'h22] = 9'b101_111_111;   // must never be latched (drain)

    //            st bt tgt    pc    ctr ra rb wa we op done
    tbl[0]  = mk(0, 0, 0,     0,    0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0,     0,    0,  0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,     0,    1,  0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,     0,    2,  0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,     0,    3,  1, 2, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 'h55,  1,    0,  1, 2, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,     1,    1,  1, 2, 1, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0,     1,    2,  1, 2, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,     1,    3,  4, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,     2,    0,  4, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, 'h77,  2,    1,  4, 0, 4, 1, 6, 0);
    tbl[11] = mk(0, 1, 'h77,  2,    2,  4, 0, 4, 0, 6, 0);
    tbl[12] = mk(0, 0, 0,     2,    3,  5, 3, 4, 0, 6, 0);
    tbl[13] = mk(0, 1, 'h20,  'h20, 0,  5, 3, 4, 0, 6, 0);
    tbl[14] = mk(0, 0, 0,     'h20, 1,  5, 3, 5, 0, 0, 0);
    tbl[15] = mk(0, 0, 0,     'h20, 2,  5, 3, 5, 0, 0, 0);
    tbl[16] = mk(0, 0, 0,     'h20, 3,  2, 1, 5, 0, 0, 0);
    tbl[17] = mk(0, 0, 0,     'h21, 0,  2, 1, 5, 0, 0, 0);
    tbl[18] = mk(0, 0, 0,     'h21, 1,  2, 1, 2, 1, 7, 0);
    tbl[19] = mk(0, 0, 0,     'h21, 2,  2, 1, 2, 0, 7, 0);
    tbl[20] = mk(0, 0, 0,     'h21, 3,  0, 0, 2, 0, 7, 0);
    tbl[21] = mk(1, 0, 0,     'h22, 0,  0, 0, 2, 0, 7, 0);
    tbl[22] = mk(1, 0, 0,     'h22, 1,  0, 0, 0, 0, 7, 0);
    tbl[23] = mk(0, 0, 0,     'h22, 0,  0, 0, 0, 0, 7, 1);
    tbl[24] = mk(0, 0, 0,     'h22, 0,  0, 0, 0, 0, 7, 1);

    do_reset();
    check("reset_state", {8'h00, pack_dut()}, 32'h0);

    for (int i = 0; i < 25; i++) apply(tbl[i], $sformatf("table_row_%0d", i));

    // ---------------- restart from HALTED, writeback, branch not taken ----
    rom[8'h00] = 9'b000_011_000;
    rom[8'h01] = 9'b000_100_000;
    rom[8'h02] = 9'b110_000_000;
    rom[8'h03] = 9'b000_000_000;
    rom[8'h04] = 9'b000_000_000;

    cyc(1'b1, 1'b0, 8'h00);
    check("restart_pc", 32'(bus.pc), 32'h0);
    check("restart_done", 32'(bus.done), 32'h0);
    idle_cycles(4);
    check("instr1_pc", 32'(bus.pc), 32'h1);
    idle_cycles(1);
    check("instr1_wb_en", 32'(bus.write_en), 32'h1);
    check("instr1_wb_addr", 32'(bus.waddr), 32'h3);
    idle_cycles(6);
    cyc(1'b0, 1'b0, 8'h20);
    check("branch_not_taken_pc", 32'(bus.pc), 32'h3);
    idle_cycles(1);
    check("no_wb_after_branch", 32'(bus.write_en), 32'h0);
    idle_cycles(4);
    check("wb_before_reset", 32'(bus.write_en), 32'h1);

    // ---------------- async reset in the middle of a writeback phase -------
    init_n = 1'b0;
    #1;
    check("async_rst_write_en", 32'(bus.write_en), 32'h0);
    check("async_rst_counter", 32'(bus.counter), 32'h0);
    check("async_rst_pc", 32'(bus.pc), 32'h0);
    @(negedge CLK);
    init_n = 1'b1;
    idle_cycles(2);
    check("idle_after_reset", {8'h00, pack_dut()}, 32'h0);
    cyc(1'b1, 1'b0, 8'h00);
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    check("start_ignored_pc", 32'(bus.pc), 32'h1);
    check("start_ignored_ctr", 32'(bus.counter), 32'h0);

    // ---------------- PC wrap ----------------
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    do_reset();
    cyc(1'b1, 1'b0, 8'h00);
    idle_cycles(255 * 4);
    check("wrap_pc_ff", 32'(bus.pc), 32'hFF);
    check("wrap_ctr_ff", 32'(bus.counter), 32'h0);
    idle_cycles(4);
    check("wrap_pc_00", 32'(bus.pc), 32'h00);
    check("wrap_ctr_00", 32'(bus.counter), 32'h0);

    // ---------------- random programs vs model ----------------
    for (int r = 0; r < 8; r++) begin
      fill_random_rom();
      do_reset();
      build_round();
      foreach (q[k]) apply(q[k], $sformatf("rand_r%0d_c%0d", r, k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
